// File: rtl/pipe_ctrl_n.sv
// pipe_ctrl_n: pipeline hazard controller.
// Converts per-stage stall requests into a freeze mask, produces flush strobes
// for the stages younger than the branch-resolving stage, defers a flush that
// collides with an older stall, and tracks stall duration (watchdog) and total
// stalled cycles.
//
// Handshake note: there is no valid/ready pairing here. stall_req_i is a level
// sampled every cycle. flush_req_i is a single-cycle pulse that is always
// accepted: it either fires immediately or is parked in pend_q (visible on
// flush_pend_o) until the older stall releases. Pulses that arrive while one is
// parked merge into the parked one.
module pipe_ctrl_n #(
    parameter int NSTAGE      = 5,
    parameter int FLUSH_STAGE = 3,
    parameter int WDOG_CYCLES = 64,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stall_req_i,
    input  logic              flush_req_i,
    output logic [NSTAGE-1:0] stalled_o,
    output logic [NSTAGE-1:0] flush_o,
    output logic              flush_pend_o,
    output logic              wdog_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int              WD_W    = $clog2(WDOG_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

    // The branch stage must have at least one younger stage to kill and an
    // older stage whose stall can defer the flush.
    generate
        if (FLUSH_STAGE < 2 || FLUSH_STAGE > NSTAGE - 1) begin : g_bad_flush_stage
            $error("pipe_ctrl_n: FLUSH_STAGE must satisfy 2 <= FLUSH_STAGE <= NSTAGE-1");
        end
    endgenerate

    logic              pend_q;
    logic              pend_d;
    logic [WD_W-1:0]   wd_q;
    logic [NSTAGE-1:0] reach;
    logic              older_stall;
    logic              eff_flush;
    logic              any_stall;

    // A stall at stage k freezes every younger stage too: reach[j] is set when
    // any stage at index >= j (ignoring the pc bit) requests a stall.
    always_comb begin
        logic req_above;
        req_above = 1'b0;
        reach     = '0;
        for (int j = NSTAGE - 1; j >= 1; j--) begin
            req_above = req_above | stall_req_i[j];
            reach[j]  = req_above;
        end
        reach[0] = req_above;
    end

    assign older_stall = reach[FLUSH_STAGE];
    assign eff_flush   = flush_req_i | pend_q;

    // Resolve stall versus flush: an older stall wins and parks the flush;
    // otherwise a flush kills stages 1..FLUSH_STAGE-1 and overrides younger stalls.
    always_comb begin
        stalled_o = reach;
        flush_o   = '0;
        pend_d    = 1'b0;
        if (older_stall) begin
            pend_d = eff_flush;
        end else if (eff_flush) begin
            stalled_o = '0;
            for (int j = 1; j < FLUSH_STAGE; j++) begin
                flush_o[j] = 1'b1;
            end
        end
    end

    assign any_stall    = |stalled_o;
    assign flush_pend_o = pend_q;

    // Deferred flush register; reset discards anything parked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Watchdog: count consecutive stalled cycles, saturate at the threshold,
    // and latch the sticky timeout flag on the threshold cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q   <= '0;
            wdog_o <= 1'b0;
        end else if (any_stall) begin
            if (wd_q == WD_LAST) begin
                wdog_o <= 1'b1;
            end else begin
                wd_q <= wd_q + WD_W'(1);
            end
        end else begin
            wd_q <= '0;
        end
    end

    // Free-running count of stalled cycles, wrapping at 2^CNT_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_o <= '0;
        end else if (any_stall) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule
